mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single-ported unified memory between the instruction-fetch requester (fetch state of the control FSM / PC) and the data requester (LOD/STR in the mem state). It grants one requester at a time, drives the memory port for a fixed access latency and returns read data with a one-cycle acknowledge. A bounded-deferral rule prevents fetch starvation under back-to-back data traffic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYC, 2, memory access cycles per transaction (legal range 1–15)
- MAX_DEFER, 3, consecutive fetch losses tolerated before fetch is forced to win (legal range 1–7)

- CLK  in  1  clock, rising edge
- RST_F  in  1  reset, asynchronous, active-low
- I_REQ  in  1  fetch request, held high until acknowledged
- I_ADDR  in  ADDR_W  fetch address
- I_ACK  out  1  fetch done, one-cycle pulse
- I_RDATA  out  DATA_W  fetched instruction
- D_REQ  in  1  data request, held high until acknowledged
- D_WE  in  1  1 = store (STR), 0 = load (LOD)
- D_ADDR  in  ADDR_W  data address
- D_WDATA  in  DATA_W  store data
- D_ACK  out  1  data done, one-cycle pulse
- D_RDATA  out  DATA_W  load data
- M_CS  out  1  memory chip select
- M_WE  out  1  memory write enable
- M_ADDR  out  ADDR_W  memory address
- M_WDATA  out  DATA_W  memory write data
- M_RDATA  in  DATA_W  memory read data, valid on the last access cycle
- BUSY  out  1  high whenever the FSM is not in IDLE

## Operation
- All outputs are registered.
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Only one requester active: grant it.
  - Both requesters active: data wins unless defer_cnt == MAX_DEFER, in which case fetch wins.
  - On a grant: latch owner, address, WE and write data into M_*; assert M_CS; M_WE = D_WE for a data owner, 0 for fetch; load wait_cnt = WAIT_CYC−1; go to ACCESS.
- **ACCESS**
  - M_CS stays high and M_* stays stable.
  - wait_cnt decrements each cycle.
  - When wait_cnt == 0: capture M_RDATA into the owner's RDATA register (loads and fetches only; stores leave D_RDATA unchanged), drop M_CS/M_WE, pulse the owner's ACK and go to DONE.
- **DONE**
  - ACK is high for exactly this cycle.
  - The requester clears REQ on the edge that samples ACK high.
  - Always go to IDLE next.
- **Deferral counter (defer_cnt)**
  - Increments (saturating at MAX_DEFER) whenever both requests are present in IDLE and data is granted.
  - Clears to 0 whenever fetch is granted.
  - Unchanged otherwise.
- Requests that arrive during ACCESS or DONE wait; they are arbitrated in the next IDLE cycle.
- REQ dropped before ACK is a protocol violation. The transaction still completes and ACK still pulses.
- I_RDATA and D_RDATA hold their value until overwritten by the next read for that port.

## Timing
- Reset (RST_F low, asynchronous): state = IDLE, M_CS = 0, M_WE = 0, M_ADDR = 0, M_WDATA = 0, I_ACK = 0, D_ACK = 0, I_RDATA = 0, D_RDATA = 0, BUSY = 0, defer_cnt = 0.
  - Asserting RST_F mid-ACCESS aborts the access immediately and no ACK is issued.
  - On the first edge after RST_F rises the FSM is in IDLE, and it may grant on that edge.
- Latency: REQ sampled high in IDLE at edge N gives ACCESS on cycles N+1 … N+WAIT_CYC and ACK high in cycle N+WAIT_CYC+1.
- Back-to-back throughput is one transaction per WAIT_CYC+2 cycles (grant, WAIT_CYC access cycles, DONE).
- M_CS is high for exactly WAIT_CYC cycles per transaction.
- M_ADDR, M_WDATA and M_WE are constant while M_CS is high.
- I_ACK and D_ACK are never high in the same cycle.
- BUSY is high in ACCESS and DONE.

## Test plan
- Reset check: hold RST_F low with I_REQ = D_REQ = 1 → all outputs 0 and M_CS never asserts; release → fetch-vs-data arbitration starts at the first edge.
- Single fetch, WAIT_CYC = 2: I_ADDR = 0x10, memory returns 0x8000_0001 → M_CS high for 2 cycles at 0x10, I_ACK pulses in cycle 3 after the grant edge, I_RDATA = 0x8000_0001.
- Collision: I_REQ and D_REQ rise together, D_WE = 0, D_ADDR = 0x20 → data served first with D_ACK, then fetch granted in the next IDLE, and defer_cnt returns to 0 after the fetch grant.
- Starvation guard, MAX_DEFER = 3: D_REQ reasserted every IDLE with I_REQ held high → three data transactions, fourth grant goes to fetch.
- Store: D_WE = 1, D_ADDR = 0x44, D_WDATA = 0xDEAD_BEEF → M_WE = 1 for WAIT_CYC cycles with stable address/data, D_ACK pulses, D_RDATA unchanged.
- Reset mid-op: RST_F pulsed low during ACCESS of a fetch → M_CS drops asynchronously, no I_ACK, defer_cnt = 0, and a re-issued fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and data load/store,
// with a bounded-deferral rule so back-to-back data traffic cannot starve fetch.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned WAIT_CYC  = 2,
   parameter int unsigned MAX_DEFER = 3
) (
   input  logic              CLK,
   input  logic              RST_F,
   input  logic              I_REQ,
   input  logic [ADDR_W-1:0] I_ADDR,
   output logic              I_ACK,
   output logic [DATA_W-1:0] I_RDATA,
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic [ADDR_W-1:0] D_ADDR,
   input  logic [DATA_W-1:0] D_WDATA,
   output logic              D_ACK,
   output logic [DATA_W-1:0] D_RDATA,
   output logic              M_CS,
   output logic              M_WE,
   output logic [ADDR_W-1:0] M_ADDR,
   output logic [DATA_W-1:0] M_WDATA,
   input  logic [DATA_W-1:0] M_RDATA,
   output logic              BUSY
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned DEF_W = 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [DEF_W-1:0] defer_cnt;
   logic             owner_data;
   logic             grant_i_c;
   logic             grant_d_c;

   // Data wins a collision unless fetch has already lost MAX_DEFER times in a row
   always_comb begin
      grant_i_c = 1'b0;
      grant_d_c = 1'b0;
      if (I_REQ && (!D_REQ || (defer_cnt == DEF_W'(MAX_DEFER)))) begin
         grant_i_c = 1'b1;
      end else if (D_REQ) begin
         grant_d_c = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_F) begin
      if (!RST_F) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         defer_cnt  <= '0;
         owner_data <= 1'b0;
         M_CS       <= 1'b0;
         M_WE       <= 1'b0;
         M_ADDR     <= '0;
         M_WDATA    <= '0;
         I_ACK      <= 1'b0;
         D_ACK      <= 1'b0;
         I_RDATA    <= '0;
         D_RDATA    <= '0;
         BUSY       <= 1'b0;
      end else begin
         I_ACK <= 1'b0;
         D_ACK <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_d_c) begin
                  state      <= S_ACCESS;
                  BUSY       <= 1'b1;
                  M_CS       <= 1'b1;
                  M_WE       <= D_WE;
                  M_ADDR     <= D_ADDR;
                  M_WDATA    <= D_WDATA;
                  owner_data <= 1'b1;
                  wait_cnt   <= CNT_W'(WAIT_CYC - 1);
                  if (I_REQ && (defer_cnt < DEF_W'(MAX_DEFER))) begin
                     defer_cnt <= defer_cnt + DEF_W'(1);
                  end
               end else if (grant_i_c) begin
                  state      <= S_ACCESS;
                  BUSY       <= 1'b1;
                  M_CS       <= 1'b1;
                  M_WE       <= 1'b0;
                  M_ADDR     <= I_ADDR;
                  owner_data <= 1'b0;
                  wait_cnt   <= CNT_W'(WAIT_CYC - 1);
                  defer_cnt  <= '0;
               end
            end
            S_ACCESS: begin
               // Memory data is valid on the last access cycle; stores leave D_RDATA alone
               if (wait_cnt == '0) begin
                  state <= S_DONE;
                  M_CS  <= 1'b0;
                  M_WE  <= 1'b0;
                  if (owner_data) begin
                     D_ACK <= 1'b1;
                     if (!M_WE) begin
                        D_RDATA <= M_RDATA;
                     end
                  end else begin
                     I_ACK   <= 1'b1;
                     I_RDATA <= M_RDATA;
                  end
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
               M_CS  <= 1'b0;
               M_WE  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory model answers the port, expected
// transactions are queued in service order and checked at M_CS rise and at each ACK.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned WAIT_CYC  = 2;
   localparam int unsigned MAX_DEFER = 3;

   logic              CLK;
   logic              RST_F;
   logic              I_REQ;
   logic [ADDR_W-1:0] I_ADDR;
   logic              I_ACK;
   logic [DATA_W-1:0] I_RDATA;
   logic              D_REQ;
   logic              D_WE;
   logic [ADDR_W-1:0] D_ADDR;
   logic [DATA_W-1:0] D_WDATA;
   logic              D_ACK;
   logic [DATA_W-1:0] D_RDATA;
   logic              M_CS;
   logic              M_WE;
   logic [ADDR_W-1:0] M_ADDR;
   logic [DATA_W-1:0] M_WDATA;
   logic [DATA_W-1:0] M_RDATA;
   logic              BUSY;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC), .MAX_DEFER(MAX_DEFER)
   ) dut (
      .CLK(CLK), .RST_F(RST_F),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_ACK(D_ACK), .D_RDATA(D_RDATA),
      .M_CS(M_CS), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA),
      .BUSY(BUSY)
   );

   typedef struct {
      logic              is_data;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rdata;
   } want_t;

   want_t             want_q[$];
   int                n_checks = 0;
   int                n_errors = 0;
   logic [DATA_W-1:0] d_last = '0;
   logic [DATA_W-1:0] ref_mem [256];
   bit                ref_val [256];
   logic [DATA_W-1:0] wmem [256];
   bit                wval [256];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, want, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
      return (a == 32'h10) ? 32'h8000_0001 : (32'h5A00_0000 ^ a);
   endfunction

   // Memory model: unwritten words return init_val, stores land on the clock edge
   always_comb begin
      M_RDATA = wval[M_ADDR[7:0]] ? wmem[M_ADDR[7:0]] : init_val(M_ADDR);
   end

   always @(posedge CLK) begin
      if (RST_F && M_CS && M_WE) begin
         wmem[M_ADDR[7:0]] <= M_WDATA;
         wval[M_ADDR[7:0]] <= 1'b1;
      end
   end

   function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
      return ref_val[a[7:0]] ? ref_mem[a[7:0]] : init_val(a);
   endfunction

   task automatic push_fetch(input logic [ADDR_W-1:0] a);
      want_q.push_back('{is_data: 1'b0, we: 1'b0, addr: a, wdata: '0, rdata: ref_rd(a)});
   endtask

   task automatic push_load(input logic [ADDR_W-1:0] a);
      d_last = ref_rd(a);
      want_q.push_back('{is_data: 1'b1, we: 1'b0, addr: a, wdata: '0, rdata: d_last});
   endtask

   task automatic push_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
      ref_mem[a[7:0]] = wd;
      ref_val[a[7:0]] = 1'b1;
      want_q.push_back('{is_data: 1'b1, we: 1'b1, addr: a, wdata: wd, rdata: d_last});
   endtask

   // Monitor: port contents at M_CS rise, stability while selected, ACK ordering and data
   logic              in_cs = 1'b0;
   int                cs_len = 0;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_wdata;
   logic              cap_we;
   want_t             mon_w;

   always @(negedge CLK) begin
      if (!RST_F) begin
         in_cs  = 1'b0;
         cs_len = 0;
      end else begin
         check("ack_exclusive", 64'(I_ACK & D_ACK), 64'd0);
         check("busy", 64'(BUSY), 64'(M_CS | I_ACK | D_ACK));
         if (M_CS) begin
            if (!in_cs) begin
               if (want_q.size() == 0) begin
                  check("cs_unexpected", 64'd1, 64'd0);
               end else begin
                  mon_w = want_q[0];
                  check("m_addr", 64'(M_ADDR), 64'(mon_w.addr));
                  check("m_we", 64'(M_WE), 64'(mon_w.is_data & mon_w.we));
                  if (mon_w.is_data && mon_w.we) check("m_wdata", 64'(M_WDATA), 64'(mon_w.wdata));
               end
               cap_addr  = M_ADDR;
               cap_wdata = M_WDATA;
               cap_we    = M_WE;
               in_cs     = 1'b1;
               cs_len    = 0;
            end else begin
               check("m_addr_stable", 64'(M_ADDR), 64'(cap_addr));
               check("m_we_stable", 64'(M_WE), 64'(cap_we));
               check("m_wdata_stable", 64'(M_WDATA), 64'(cap_wdata));
            end
            cs_len++;
         end else begin
            in_cs = 1'b0;
         end
         if (I_ACK || D_ACK) begin
            check("cs_len", 64'(cs_len), 64'(WAIT_CYC));
            if (want_q.size() == 0) begin
               check("ack_unexpected", 64'd1, 64'd0);
            end else begin
               mon_w = want_q.pop_front();
               check("ack_port", 64'(D_ACK), 64'(mon_w.is_data));
               check(mon_w.is_data ? "d_rdata" : "i_rdata",
                     64'(mon_w.is_data ? D_RDATA : I_RDATA), 64'(mon_w.rdata));
            end
         end
      end
   end

   task automatic do_fetch(input logic [ADDR_W-1:0] a, output int cyc);
      I_ADDR = a;
      I_REQ  = 1'b1;
      cyc    = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (!I_ACK && cyc < 100);
      if (!I_ACK) check("i_ack_timeout", 64'd0, 64'd1);
      @(posedge CLK);
      #1 I_REQ = 1'b0;
   endtask

   task automatic do_data(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, output int cyc);
      D_WE    = we;
      D_ADDR  = a;
      D_WDATA = wd;
      D_REQ   = 1'b1;
      cyc     = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (!D_ACK && cyc < 100);
      if (!D_ACK) check("d_ack_timeout", 64'd0, 64'd1);
      @(posedge CLK);
      #1 D_REQ = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c1, c2, kind;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;

      RST_F = 1'b0; I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
      I_ADDR = 32'h10; D_ADDR = 32'h20; D_WDATA = '0;

      // Reset held with both requests pending
      I_REQ = 1'b1; D_REQ = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         check("rst_m_cs", 64'(M_CS), 64'd0);
      end
      check("rst_outputs", {I_ACK, D_ACK, M_WE, BUSY, I_RDATA, D_RDATA}, 64'd0);
      check("rst_m_port", {M_ADDR, M_WDATA}, 64'd0);
      check("rst_defer", 64'(dut.defer_cnt), 64'd0);

      // Release: data wins the collision on the first edge, then fetch
      push_load(32'h20);
      push_fetch(32'h10);
      fork
         do_data(1'b0, 32'h20, '0, c1);
         do_fetch(32'h10, c2);
         RST_F = 1'b1;
      join
      check("rst_first_lat", 64'(c1), 64'(WAIT_CYC + 1));
      check("rst_fetch_lat", 64'(c2), 64'(2 * WAIT_CYC + 3));
      check("rst_defer_clear", 64'(dut.defer_cnt), 64'd0);

      // Single fetch
      @(negedge CLK);
      push_fetch(32'h10);
      do_fetch(32'h10, c1);
      check("fetch_lat", 64'(c1), 64'(WAIT_CYC + 1));
      check("fetch_rdata", 64'(I_RDATA), 64'h8000_0001);

      // Collision: data first, defer counts up, fetch grant clears it
      @(negedge CLK);
      push_load(32'h20);
      push_fetch(32'h18);
      fork
         do_data(1'b0, 32'h20, '0, c1);
         do_fetch(32'h18, c2);
         begin
            @(posedge CLK);
            #1 check("coll_defer_one", 64'(dut.defer_cnt), 64'd1);
         end
      join
      check("coll_defer_zero", 64'(dut.defer_cnt), 64'd0);

      // Starvation guard: three data wins, then fetch is forced through
      @(negedge CLK);
      push_load(32'h30); push_load(32'h34); push_load(32'h38);
      push_fetch(32'h40);
      push_load(32'h3C);
      fork
         do_fetch(32'h40, c2);
         begin
            for (int k = 1; k <= 3; k++) begin
               do_data(1'b0, 32'h30 + 32'(4 * (k - 1)), '0, c1);
               check("starve_defer", 64'(dut.defer_cnt), 64'(k));
            end
            do_data(1'b0, 32'h3C, '0, c1);
            check("starve_defer_after", 64'(dut.defer_cnt), 64'd0);
         end
      join
      check("starve_fetch_lat", 64'(c2), 64'(3 * (WAIT_CYC + 2) + WAIT_CYC + 1));

      // Store leaves D_RDATA untouched; a following load sees the stored word
      @(negedge CLK);
      push_store(32'h44, 32'hDEAD_BEEF);
      do_data(1'b1, 32'h44, 32'hDEAD_BEEF, c1);
      check("store_lat", 64'(c1), 64'(WAIT_CYC + 1));
      check("store_d_rdata_hold", 64'(D_RDATA), 64'(d_last));
      @(negedge CLK);
      push_load(32'h44);
      do_data(1'b0, 32'h44, '0, c1);
      check("store_readback", 64'(D_RDATA), 64'hDEAD_BEEF);

      // Reset in the middle of a fetch access
      @(negedge CLK);
      push_fetch(32'h50);
      I_ADDR = 32'h50;
      I_REQ  = 1'b1;
      @(posedge CLK);
      #1 check("midrst_cs_on", 64'(M_CS), 64'd1);
      #2 RST_F = 1'b0;
      #1 check("midrst_cs_off", 64'(M_CS), 64'd0);
      check("midrst_busy", 64'(BUSY), 64'd0);
      check("midrst_defer", 64'(dut.defer_cnt), 64'd0);
      want_q.delete();
      repeat (2) begin
         @(negedge CLK);
         check("midrst_no_ack", 64'(I_ACK), 64'd0);
      end
      RST_F = 1'b1;
      push_fetch(32'h50);
      do_fetch(32'h50, c1);
      check("midrst_refetch_lat", 64'(c1), 64'(WAIT_CYC + 1));

      // Mixed random traffic
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         kind = int'($urandom_range(0, 2));
         a    = 32'($urandom_range(0, 63)) << 2;
         wd   = $urandom;
         case (kind)
            0: begin push_fetch(a); do_fetch(a, c1); end
            1: begin push_load(a); do_data(1'b0, a, '0, c1); end
            default: begin push_store(a, wd); do_data(1'b1, a, wd, c1); end
         endcase
         check("rand_lat", 64'(c1), 64'(WAIT_CYC + 1));
      end

      @(negedge CLK);
      check("scoreboard_empty", 64'(want_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
